// File: rtl/plab5_mcore_mem_port_arbiter.sv
// Purpose: shares one memory-network request port between icache (port 0) and dcache (port 1)
//          refills. Requests get round-robin arbitration and a one-entry output register.
//          Each request is tagged with the requester id in the opaque MSB. Responses are
//          steered back to the requester by that tag.
// Latency: request path 1 cycle (accept -> out_req_val). Response path 0 cycles.
// Backpressure: in*_req_rdy drops while the output stage is full and not draining, or while
//               p_max_outstanding requests are unanswered. in_resp_rdy follows the rdy of the
//               addressed requester.
// Ports: in0/in1 request val/rdy/msg, out request val/rdy/msg, in response val/rdy/msg,
//        out0/out1 response val/rdy/msg.
module plab5_mcore_mem_port_arbiter #(
  parameter int p_opaque_nbits    = 8,
  parameter int p_addr_nbits      = 32,
  parameter int p_data_nbits      = 32,
  parameter int p_max_outstanding = 4,
  // Message widths follow the vc mem message layout. The len field is log2 of the bytes per word.
  localparam int c_len_nbits = (p_data_nbits / 8 > 1) ? $clog2(p_data_nbits / 8) : 1,
  localparam int c_rq = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits + p_data_nbits,
  localparam int c_rs = 3 + p_opaque_nbits + c_len_nbits + p_data_nbits
) (
  input  logic            clk,
  input  logic            reset,

  input  logic [c_rq-1:0] in0_req_msg,
  input  logic            in0_req_val,
  output logic            in0_req_rdy,

  input  logic [c_rq-1:0] in1_req_msg,
  input  logic            in1_req_val,
  output logic            in1_req_rdy,

  output logic [c_rq-1:0] out_req_msg,
  output logic            out_req_val,
  input  logic            out_req_rdy,

  input  logic [c_rs-1:0] in_resp_msg,
  input  logic            in_resp_val,
  output logic            in_resp_rdy,

  output logic [c_rs-1:0] out0_resp_msg,
  output logic            out0_resp_val,
  input  logic            out0_resp_rdy,

  output logic [c_rs-1:0] out1_resp_msg,
  output logic            out1_resp_val,
  input  logic            out1_resp_rdy
);

  // Bit positions of the opaque MSB in the request and response messages.
  localparam int c_req_tag  = c_rq - 4;
  localparam int c_resp_tag = c_rs - 4;

  logic            prio;      // port that wins when both are valid
  logic [3:0]      cnt;       // accepted but not yet answered
  logic            free;
  logic            can_acc;
  logic            acc0;
  logic            acc1;
  logic            acc;
  logic            resp_id;
  logic            resp_hs;
  logic [c_rq-1:0] req_tagged;

  // The stage can take a new request in the same cycle it hands one to the network.
  assign free    = !out_req_val || out_req_rdy;
  assign can_acc = free && (cnt < 4'(p_max_outstanding));

  // A port is refused only when the other port is valid and wins. The other port wins if
  // this port is idle, or if both are valid and the tie-break points away. With nobody
  // valid, both ports see ready.
  assign in0_req_rdy = can_acc && (in1_req_val ? (in0_req_val && !prio) : 1'b1);
  assign in1_req_rdy = can_acc && (in0_req_val ? (in1_req_val &&  prio) : 1'b1);

  assign acc0 = in0_req_val && in0_req_rdy;
  assign acc1 = in1_req_val && in1_req_rdy;
  assign acc  = acc0 || acc1;

  // Whatever the requester drives in the opaque MSB is replaced by its port id.
  always_comb begin
    req_tagged            = acc1 ? in1_req_msg : in0_req_msg;
    req_tagged[c_req_tag] = acc1;
  end

  // Response steering.
  assign resp_id     = in_resp_msg[c_resp_tag];
  assign in_resp_rdy = resp_id ? out1_resp_rdy : out0_resp_rdy;
  assign resp_hs     = in_resp_val && in_resp_rdy;

  assign out0_resp_val = in_resp_val && !resp_id;
  assign out1_resp_val = in_resp_val &&  resp_id;

  always_comb begin
    out0_resp_msg             = in_resp_msg;
    out0_resp_msg[c_resp_tag] = 1'b0;
    out1_resp_msg             = out0_resp_msg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_req_val <= 1'b0;
      out_req_msg <= '0;
      prio        <= 1'b0;
      cnt         <= 4'd0;
    end else begin
      if (free) begin
        out_req_val <= acc;
        if (acc) begin
          out_req_msg <= req_tagged;
          // Hand the tie-break to the port that was not just served.
          prio        <= acc0;
        end
      end

      case ({acc, resp_hs})
        2'b10:   cnt <= cnt + 4'd1;
        // A response with nothing outstanding is a protocol error. Hold at zero instead of wrapping.
        2'b01:   cnt <= (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  a_no_resp_underflow : assert property (@(posedge clk) disable iff (reset)
      !(resp_hs && cnt == 4'd0))
    else $error("response handshake with no outstanding request");

endmodule

// File: tb/tb_plab5_mcore_mem_port_arbiter.sv
module tb_plab5_mcore_mem_port_arbiter;

  localparam int O   = 8;
  localparam int A   = 32;
  localparam int D   = 32;
  localparam int MAX = 4;
  localparam int L   = 2;
  localparam int RQ  = 3 + O + A + L + D;
  localparam int RS  = 3 + O + L + D;

  logic          clk = 1'b0;
  logic          reset;
  logic [RQ-1:0] in0_req_msg, in1_req_msg, out_req_msg;
  logic          in0_req_val, in0_req_rdy, in1_req_val, in1_req_rdy;
  logic          out_req_val, out_req_rdy;
  logic [RS-1:0] in_resp_msg, out0_resp_msg, out1_resp_msg;
  logic          in_resp_val, in_resp_rdy;
  logic          out0_resp_val, out0_resp_rdy, out1_resp_val, out1_resp_rdy;

  plab5_mcore_mem_port_arbiter #(
    .p_opaque_nbits(O), .p_addr_nbits(A), .p_data_nbits(D), .p_max_outstanding(MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .in0_req_msg(in0_req_msg), .in0_req_val(in0_req_val), .in0_req_rdy(in0_req_rdy),
    .in1_req_msg(in1_req_msg), .in1_req_val(in1_req_val), .in1_req_rdy(in1_req_rdy),
    .out_req_msg(out_req_msg), .out_req_val(out_req_val), .out_req_rdy(out_req_rdy),
    .in_resp_msg(in_resp_msg), .in_resp_val(in_resp_val), .in_resp_rdy(in_resp_rdy),
    .out0_resp_msg(out0_resp_msg), .out0_resp_val(out0_resp_val), .out0_resp_rdy(out0_resp_rdy),
    .out1_resp_msg(out1_resp_msg), .out1_resp_val(out1_resp_val), .out1_resp_rdy(out1_resp_rdy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model, kept at the level of "what the port promises":
  // a one-slot holding buffer, the port that wins the next tie, the number of unanswered
  // requests, and the opaques of requests the network has already taken (awaiting response).
  logic          m_busy;
  logic [RQ-1:0] m_slot;
  int            m_tie;
  int            m_out;
  logic [O-1:0]  issued[$];

  // Grant counts for the alternation check.
  int g_cnt[2];

  function automatic logic [RQ-1:0] rand_req();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[RQ-1:0];
  endfunction

  function automatic logic [RS-1:0] rand_resp();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[RS-1:0];
  endfunction

  // One cycle: drive at negedge, check at negedge+1, advance the model, let posedge happen.
  task automatic step(input int pv0, input int pv1, input int pordy, input int presp, input bit do_rst);
    int            idx;
    int            winner;
    int            rid;
    bit            can, e_rdy0, e_rdy1, e_rhs;
    logic [RQ-1:0] nmsg;
    logic [RS-1:0] r;

    @(negedge clk);
    reset         = do_rst;
    in0_req_val   = ($urandom_range(99) < pv0);
    in1_req_val   = ($urandom_range(99) < pv1);
    in0_req_msg   = rand_req();
    in1_req_msg   = rand_req();
    out_req_rdy   = ($urandom_range(99) < pordy);
    out0_resp_rdy = ($urandom_range(99) < 70);
    out1_resp_rdy = ($urandom_range(99) < 70);
    idx = -1;
    in_resp_val = 1'b0;
    r = rand_resp();
    if (issued.size() > 0 && $urandom_range(99) < presp) begin
      idx = $urandom_range(issued.size() - 1);
      r[RS-4 -: O] = issued[idx];
      in_resp_val = 1'b1;
    end
    in_resp_msg = r;
    #1;

    if (do_rst) begin
      m_busy = 1'b0; m_slot = '0; m_tie = 0; m_out = 0;
      issued.delete();
      return;
    end

    // Requests: who is allowed in this cycle.
    can    = (!m_busy || out_req_rdy) && (m_out < MAX);
    winner = -1;
    if (in0_req_val && in1_req_val) winner = m_tie;
    else if (in0_req_val)           winner = 0;
    else if (in1_req_val)           winner = 1;
    e_rdy0 = can && (winner == 0 || winner == -1);
    e_rdy1 = can && (winner == 1 || winner == -1);

    check("in0_req_rdy", 128'(in0_req_rdy), 128'(e_rdy0));
    check("in1_req_rdy", 128'(in1_req_rdy), 128'(e_rdy1));
    check("out_req_val", 128'(out_req_val), 128'(m_busy));
    if (m_busy) check("out_req_msg", 128'(out_req_msg), 128'(m_slot));

    // Responses: steered by tag, tag cleared on the way out.
    rid = int'(r[RS-4]);
    check("out0_resp_val", 128'(out0_resp_val), 128'(in_resp_val && rid == 0));
    check("out1_resp_val", 128'(out1_resp_val), 128'(in_resp_val && rid == 1));
    check("in_resp_rdy", 128'(in_resp_rdy), 128'(rid == 1 ? out1_resp_rdy : out0_resp_rdy));
    r[RS-4] = 1'b0;
    if (in_resp_val && rid == 0) check("out0_resp_msg", 128'(out0_resp_msg), 128'(r));
    if (in_resp_val && rid == 1) check("out1_resp_msg", 128'(out1_resp_msg), 128'(r));
    e_rhs = in_resp_val && (rid == 1 ? out1_resp_rdy : out0_resp_rdy);

    // Advance the model to what should be visible after the coming edge.
    if (m_busy && out_req_rdy) issued.push_back(m_slot[RQ-4 -: O]);
    if (e_rhs) begin
      issued.delete(idx);
      m_out--;
    end
    if (can && winner != -1) begin
      nmsg = (winner == 1) ? in1_req_msg : in0_req_msg;
      nmsg[RQ-4] = (winner == 1);
      m_slot = nmsg;
      m_busy = 1'b1;
      m_tie  = 1 - winner;
      m_out++;
      g_cnt[winner]++;
    end else if (!m_busy || out_req_rdy) begin
      m_busy = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    in0_req_val = 0; in1_req_val = 0; in0_req_msg = '0; in1_req_msg = '0;
    out_req_rdy = 0; in_resp_val = 0; in_resp_msg = '0;
    out0_resp_rdy = 0; out1_resp_rdy = 0;
    g_cnt[0] = 0; g_cnt[1] = 0;

    // Reset held for two cycles, then quiet cycles with the fresh state checked.
    step(0, 0, 0, 0, 1'b1);
    step(0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 0, 100, 0, 1'b0);

    // Mixed traffic.
    for (int i = 0; i < 300; i++) step(50, 50, 70, 50, 1'b0);

    // Both ports always valid with a fast network: grants must alternate evenly.
    g_cnt[0] = 0; g_cnt[1] = 0;
    for (int i = 0; i < 100; i++) step(100, 100, 100, 90, 1'b0);
    check("alternation_balance", 128'(g_cnt[0] - g_cnt[1] + 1), 128'(g_cnt[0] >= g_cnt[1] ? 1 + (g_cnt[0] > g_cnt[1]) : 0));

    // No responses: the outstanding cap must stop acceptance at MAX.
    for (int i = 0; i < 30; i++) step(100, 100, 100, 0, 1'b0);
    check("cap_reached", 128'(m_out), 128'(MAX));
    // Drain the cap one response at a time.
    for (int i = 0; i < 40; i++) step(100, 100, 100, 15, 1'b0);

    // Heavy network backpressure.
    for (int i = 0; i < 150; i++) step(80, 80, 20, 30, 1'b0);

    // Reset in the middle of traffic.
    for (int i = 0; i < 20; i++) step(70, 70, 50, 20, 1'b0);
    step(70, 70, 50, 0, 1'b1);
    for (int i = 0; i < 250; i++) step(60, 40, 80, 60, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
